// File: rtl/count_run_controller.sv
// Run controller for a WIDTH-bit up/down counter: load, step to end value, pulse done, return idle.
// Optional per-step prescaler enabled by defining COUNT_PRESCALE_EN.
module count_run_controller #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             abort,
  input  logic             pause,
  input  logic             dir,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH-1:0] end_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    DONE  = 3'd3
  } state_t;

  state_t           st, st_nx;
  logic [WIDTH-1:0] count_nx;
  logic [WIDTH-1:0] end_q, end_nx;
  logic             dir_q, dir_nx;
  logic             tick;

`ifdef COUNT_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_nx;

  assign tick = (pre_q == PRE_MAX);

  // Prescaler advances on every RUN cycle and is frozen outside RUN.
  always_comb begin
    pre_nx = pre_q;
    case (st)
      IDLE:    if (start) pre_nx = '0;
      RUN: begin
        if (abort)     pre_nx = '0;
        else if (tick) pre_nx = '0;
        else           pre_nx = pre_q + PW'(1);
      end
      default: pre_nx = pre_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) pre_q <= '0;
    else      pre_q <= pre_nx;
  end
`else
  // PRESCALE has no effect in this build; every cycle is a count step.
  assign tick = (PRESCALE >= 0) ? 1'b1 : 1'b1;
`endif

  always_comb begin
    st_nx    = st;
    count_nx = count;
    end_nx   = end_q;
    dir_nx   = dir_q;
    case (st)
      IDLE: begin
        if (start) begin
          st_nx    = RUN;
          count_nx = start_val;
          end_nx   = end_val;
          dir_nx   = dir;
        end
      end
      RUN: begin
        if (abort)                st_nx = IDLE;
        else if (count == end_q)  st_nx = DONE;
        else if (pause)           st_nx = PAUSE;
        else if (tick)            count_nx = dir_q ? count + WIDTH'(1) : count - WIDTH'(1);
      end
      PAUSE: begin
        if (abort)       st_nx = IDLE;
        else if (!pause) st_nx = RUN;
      end
      DONE:    st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      st    <= IDLE;
      count <= '0;
      end_q <= '0;
      dir_q <= 1'b0;
    end else begin
      st    <= st_nx;
      count <= count_nx;
      end_q <= end_nx;
      dir_q <= dir_nx;
    end
  end

  assign busy  = (st == RUN) || (st == PAUSE);
  assign done  = (st == DONE);
  assign state = st;

endmodule

// File: tb/tb_count_run_controller.sv
// Directed, table-driven bench for count_run_controller (WIDTH=4, PRESCALE=4).
module tb_count_run_controller;

  logic       clk = 1'b0;
  logic       clr, start, abort, pause, dir;
  logic [3:0] start_val, end_val;
  logic [3:0] count;
  logic       busy, done;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  count_run_controller #(.WIDTH(4), .PRESCALE(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .abort     (abort),
    .pause     (pause),
    .dir       (dir),
    .start_val (start_val),
    .end_val   (end_val),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .state     (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr, start, abort, pause, dir;
    logic [3:0] sv, ev;
    logic [3:0] cnt;
    logic       busy, done;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic c, input logic s, input logic a, input logic p, input logic d,
                     input logic [3:0] sv, input logic [3:0] ev,
                     input logic [3:0] cnt, input logic b, input logic dn, input logic [2:0] st);
    vec_t v;
    v.clr = c; v.start = s; v.abort = a; v.pause = p; v.dir = d;
    v.sv = sv; v.ev = ev; v.cnt = cnt; v.busy = b; v.done = dn; v.st = st;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] cnt, input logic b,
                       input logic dn, input logic [2:0] st);
    checks++;
    if (count !== cnt || busy !== b || done !== dn || state !== st) begin
      errors++;
      $display("FAIL %s: got count=%0d busy=%b done=%b state=%0d, want count=%0d busy=%b done=%b state=%0d",
               name, count, busy, done, state, cnt, b, dn, st);
    end
  endtask

  task automatic run_table();
    foreach (vecs[i]) begin
      clr = vecs[i].clr; start = vecs[i].start; abort = vecs[i].abort;
      pause = vecs[i].pause; dir = vecs[i].dir;
      start_val = vecs[i].sv; end_val = vecs[i].ev;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].busy, vecs[i].done, vecs[i].st);
    end
    vecs.delete();
  endtask

  initial begin
    clr = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0; dir = 1'b0;
    start_val = '0; end_val = '0;

    // Reset held two cycles with start asserted
    add(0,1,0,0,1,3,5, 0,0,0,0);
    add(0,1,0,0,1,3,5, 0,0,0,0);

`ifndef COUNT_PRESCALE_EN
    // Up run 3->5; inputs change mid-run, start during RUN and DONE ignored
    add(1,1,0,0,1,3,5, 3,1,0,1);
    add(1,0,0,0,0,9,9, 4,1,0,1);
    add(1,0,0,0,0,9,9, 5,1,0,1);
    add(1,1,0,0,1,3,5, 5,0,1,3);
    add(1,1,0,0,1,3,5, 5,0,0,0);
    add(1,0,0,0,1,3,5, 5,0,0,0);
    // Wrap up 14->1
    add(1,1,0,0,1,14,1, 14,1,0,1);
    add(1,0,0,0,1,14,1, 15,1,0,1);
    add(1,0,0,0,1,14,1,  0,1,0,1);
    add(1,0,0,0,1,14,1,  1,1,0,1);
    add(1,0,0,0,1,14,1,  1,0,1,3);
    add(1,0,0,0,1,14,1,  1,0,0,0);
    // Wrap down 1->14
    add(1,1,0,0,0,1,14,  1,1,0,1);
    add(1,0,0,0,1,1,14,  0,1,0,1);
    add(1,0,0,0,1,1,14, 15,1,0,1);
    add(1,0,0,0,1,1,14, 14,1,0,1);
    add(1,0,0,0,1,1,14, 14,0,1,3);
    add(1,0,0,0,1,1,14, 14,0,0,0);
    // start_val == end_val
    add(1,1,0,0,1,6,6, 6,1,0,1);
    add(1,0,0,0,1,6,6, 6,0,1,3);
    add(1,0,0,0,1,6,6, 6,0,0,0);
    // start+abort in IDLE: start wins; abort in RUN
    add(1,1,1,0,1,2,4, 2,1,0,1);
    add(1,0,1,0,1,2,4, 2,0,0,0);
    // 0->9 up, pause 3 cycles at 4, resume, abort at 7
    add(1,1,0,0,1,0,9, 0,1,0,1);
    add(1,0,0,0,1,0,9, 1,1,0,1);
    add(1,0,0,0,1,0,9, 2,1,0,1);
    add(1,0,0,0,1,0,9, 3,1,0,1);
    add(1,0,0,0,1,0,9, 4,1,0,1);
    add(1,0,0,1,1,0,9, 4,1,0,2);
    add(1,0,0,1,1,0,9, 4,1,0,2);
    add(1,0,0,1,1,0,9, 4,1,0,2);
    add(1,0,0,0,1,0,9, 4,1,0,1);
    add(1,0,0,0,1,0,9, 5,1,0,1);
    add(1,0,0,0,1,0,9, 6,1,0,1);
    add(1,0,0,0,1,0,9, 7,1,0,1);
    add(1,0,1,0,1,0,9, 7,0,0,0);
    add(1,0,0,0,1,0,9, 7,0,0,0);
    // Abort while paused
    add(1,1,0,0,1,0,9, 0,1,0,1);
    add(1,0,0,1,1,0,9, 0,1,0,2);
    add(1,0,1,1,1,0,9, 0,0,0,0);
    // Reset mid-run at count 5
    add(1,1,0,0,1,2,9, 2,1,0,1);
    add(1,0,0,0,1,2,9, 3,1,0,1);
    add(1,0,0,0,1,2,9, 4,1,0,1);
    add(1,0,0,0,1,2,9, 5,1,0,1);
    add(0,1,0,0,1,2,9, 0,0,0,0);
    add(1,0,0,0,1,2,9, 0,0,0,0);
    run_table();

    // Full-span run 0->15: done must appear 16 edges after the start edge, for one cycle
    begin
      int n;
      start_val = 4'd0; end_val = 4'd15; dir = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (!done && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      checks++;
      if (done !== 1'b1 || n != 16) begin
        errors++;
        $display("FAIL span15_latency: got done=%b after %0d edges, want done=1 after 16", done, n);
      end
      check("span15_done_pos", 4'd15, 1'b0, 1'b1, 3'd3);
      @(posedge clk); #1;
      check("span15_done_drop", 4'd15, 1'b0, 1'b0, 3'd0);
    end
`else
    // Prescaled 3->5: steps at edges 5 and 9, done at 10
    add(1,1,0,0,1,3,5, 3,1,0,1);
    for (int unsigned k = 0; k < 3; k++) add(1,0,0,0,1,3,5, 3,1,0,1);
    add(1,0,0,0,1,3,5, 4,1,0,1);
    for (int unsigned k = 0; k < 3; k++) add(1,0,0,0,1,3,5, 4,1,0,1);
    add(1,0,0,0,1,3,5, 5,1,0,1);
    add(1,0,0,0,1,3,5, 5,0,1,3);
    add(1,0,0,0,1,3,5, 5,0,0,0);
    // Same run with pause sampled high at edges 3 and 4: later edges shift by 2
    add(1,1,0,0,1,3,5, 3,1,0,1);
    add(1,0,0,0,1,3,5, 3,1,0,1);
    add(1,0,0,1,1,3,5, 3,1,0,2);
    add(1,0,0,1,1,3,5, 3,1,0,2);
    add(1,0,0,0,1,3,5, 3,1,0,1);
    add(1,0,0,0,1,3,5, 3,1,0,1);
    add(1,0,0,0,1,3,5, 4,1,0,1);
    for (int unsigned k = 0; k < 3; k++) add(1,0,0,0,1,3,5, 4,1,0,1);
    add(1,0,0,0,1,3,5, 5,1,0,1);
    add(1,0,0,0,1,3,5, 5,0,1,3);
    add(1,0,0,0,1,3,5, 5,0,0,0);
    run_table();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
